// File: rtl/vq6_pkg.sv
// Shared constants, controller states and element types for the VQ6 sorting sequencer.
package vq6_pkg;

    localparam int unsigned NE = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSort = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef logic signed [DW-1:0] score_t;
    typedef logic [AW-1:0]        addr_t;

endpackage

// File: rtl/vq6_cmp_pair.sv
// Combinational max/min cell; addresses travel with their scores, ties keep input A on top.
module vq6_cmp_pair #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic signed [DW-1:0] a_score_i,
    input  logic        [AW-1:0] a_addr_i,
    input  logic signed [DW-1:0] b_score_i,
    input  logic        [AW-1:0] b_addr_i,
    output logic signed [DW-1:0] hi_score_o,
    output logic        [AW-1:0] hi_addr_o,
    output logic signed [DW-1:0] lo_score_o,
    output logic        [AW-1:0] lo_addr_o
);

    logic keep_order;

    // Non-strict compare: equal scores never swap, which keeps the whole sort stable.
    assign keep_order = (a_score_i >= b_score_i);

    assign hi_score_o = keep_order ? a_score_i : b_score_i;
    assign hi_addr_o  = keep_order ? a_addr_i  : b_addr_i;
    assign lo_score_o = keep_order ? b_score_i : a_score_i;
    assign lo_addr_o  = keep_order ? b_addr_i  : a_addr_i;

endmodule

// File: rtl/vq6_sort_seq.sv
// Six-entry descending sorter: odd-even transposition, one phase per cycle on three shared cells.
module vq6_sort_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3,
    parameter int unsigned NE = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NE*DW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NE*DW-1:0]   out_data,
    output logic [NE*AW-1:0]   out_addr,
    output logic               busy
);

    import vq6_pkg::*;

    localparam int unsigned NP        = NE / 2;
    localparam logic [2:0]  LastPhase = 3'(NE - 1);

    state_e                state_q;
    logic [2:0]            phase_q;
    logic signed [DW-1:0]  score_q [NE];
    logic        [AW-1:0]  addr_q  [NE];

    logic signed [DW-1:0]  cmp_a_score  [NP];
    logic signed [DW-1:0]  cmp_b_score  [NP];
    logic        [AW-1:0]  cmp_a_addr   [NP];
    logic        [AW-1:0]  cmp_b_addr   [NP];
    logic signed [DW-1:0]  cmp_hi_score [NP];
    logic signed [DW-1:0]  cmp_lo_score [NP];
    logic        [AW-1:0]  cmp_hi_addr  [NP];
    logic        [AW-1:0]  cmp_lo_addr  [NP];

    logic signed [DW-1:0]  net_score [NE];
    logic        [AW-1:0]  net_addr  [NE];
    logic                  odd_phase;

    assign odd_phase = phase_q[0];

    for (genvar c = 0; c < NP; c++) begin : g_cmp
        localparam int unsigned EvenA = 2 * c;
        // The last cell has no odd-phase pair; its inputs are don't-care then.
        localparam int unsigned OddA  = (2 * c + 2 < NE) ? 2 * c + 1 : 2 * c;

        assign cmp_a_score[c] = odd_phase ? score_q[OddA]     : score_q[EvenA];
        assign cmp_b_score[c] = odd_phase ? score_q[OddA + 1] : score_q[EvenA + 1];
        assign cmp_a_addr[c]  = odd_phase ? addr_q[OddA]      : addr_q[EvenA];
        assign cmp_b_addr[c]  = odd_phase ? addr_q[OddA + 1]  : addr_q[EvenA + 1];

        vq6_cmp_pair #(
            .DW (DW),
            .AW (AW)
        ) u_cmp (
            .a_score_i  (cmp_a_score[c]),
            .a_addr_i   (cmp_a_addr[c]),
            .b_score_i  (cmp_b_score[c]),
            .b_addr_i   (cmp_b_addr[c]),
            .hi_score_o (cmp_hi_score[c]),
            .hi_addr_o  (cmp_hi_addr[c]),
            .lo_score_o (cmp_lo_score[c]),
            .lo_addr_o  (cmp_lo_addr[c])
        );
    end

    for (genvar k = 0; k < NE; k++) begin : g_slot
        localparam int unsigned EvenCell = k / 2;
        localparam int unsigned OddCell  = (k == 0) ? 0 : (k - 1) / 2;
        localparam bit          OddHold  = (k == 0) || (k == NE - 1);
        localparam bit          EvenSlot = (k % 2 == 0);

        // Even phase: even slots are pair tops. Odd phase: odd slots are pair tops.
        assign net_score[k] = !odd_phase ? (EvenSlot ? cmp_hi_score[EvenCell]
                                                     : cmp_lo_score[EvenCell])
                            : OddHold    ? score_q[k]
                            : EvenSlot   ? cmp_lo_score[OddCell] : cmp_hi_score[OddCell];
        assign net_addr[k]  = !odd_phase ? (EvenSlot ? cmp_hi_addr[EvenCell]
                                                     : cmp_lo_addr[EvenCell])
                            : OddHold    ? addr_q[k]
                            : EvenSlot   ? cmp_lo_addr[OddCell] : cmp_hi_addr[OddCell];

        assign out_data[k*DW +: DW] = score_q[k];
        assign out_addr[k*AW +: AW] = addr_q[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            for (int k = 0; k < NE; k++) begin
                score_q[k] <= '0;
                addr_q[k]  <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int k = 0; k < NE; k++) begin
                            score_q[k] <= in_data[k*DW +: DW];
                            addr_q[k]  <= AW'(k);
                        end
                        phase_q <= '0;
                        state_q <= StSort;
                    end
                end
                StSort: begin
                    for (int k = 0; k < NE; k++) begin
                        score_q[k] <= net_score[k];
                        addr_q[k]  <= net_addr[k];
                    end
                    if (phase_q == LastPhase) begin
                        phase_q <= '0;
                        state_q <= StDone;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StSort);
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_vq6_sort_seq.sv
// Bench for vq6_sort_seq: directed vectors with literal expectations plus a per-cycle sort model.
module tb_vq6_sort_seq;

    import vq6_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NE*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [NE*DW-1:0]  out_data;
    logic [NE*AW-1:0]  out_addr;
    logic              busy;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vq6_sort_seq #(
        .DW (DW),
        .AW (AW),
        .NE (NE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [NE*DW-1:0] pack_s(input int e0, input int e1, input int e2,
                                                input int e3, input int e4, input int e5);
        logic [NE*DW-1:0] v;
        int e [NE];
        e = '{e0, e1, e2, e3, e4, e5};
        for (int k = 0; k < NE; k++) v[k*DW +: DW] = DW'(e[k]);
        return v;
    endfunction

    function automatic logic [NE*AW-1:0] pack_a(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5);
        logic [NE*AW-1:0] v;
        int a [NE];
        a = '{a0, a1, a2, a3, a4, a5};
        for (int k = 0; k < NE; k++) v[k*AW +: AW] = AW'(a[k]);
        return v;
    endfunction

    // Reference: stable descending insertion sort on plain integers.
    function automatic void ref_sort(input logic [NE*DW-1:0] v, output logic [NE*DW-1:0] d,
                                     output logic [NE*AW-1:0] a);
        int s[$];
        int ad[$];
        for (int k = 0; k < NE; k++) begin
            int val;
            int p;
            val = int'($signed(v[k*DW +: DW]));
            p = 0;
            while (p < s.size() && s[p] >= val) p++;
            s.insert(p, val);
            ad.insert(p, k);
        end
        for (int j = 0; j < NE; j++) begin
            d[j*DW +: DW] = DW'(s[j]);
            a[j*AW +: AW] = AW'(ad[j]);
        end
    endfunction

    // Cycle-level expectation: a vector is held from accept until the result is taken.
    bit               m_init = 0;
    bit               m_held = 0;
    bit               m_zero = 0;
    int               m_age  = 0;
    longint           cyc    = 0;
    longint           last_acc = -100;
    logic [NE*DW-1:0] m_data;
    logic [NE*AW-1:0] m_addr;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_init   = 1;
            m_held   = 0;
            m_zero   = 1;
            m_data   = '0;
            m_addr   = '0;
            last_acc = -100;
        end else if (m_init) begin
            if (m_held && m_age >= NE) begin
                if (out_ready) m_held = 0;
            end else if (m_held) begin
                m_age++;
            end else if (in_valid) begin
                checks++;
                if (cyc - last_acc < 8) begin
                    errs++;
                    $display("FAIL throughput: got %0d cycles between accepts, required >= 8",
                             cyc - last_acc);
                end
                last_acc = cyc;
                m_held   = 1;
                m_age    = 0;
                m_zero   = 0;
                ref_sort(in_data, m_data, m_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 64'(in_ready), 64'(!m_held));
            chk("out_valid", 64'(out_valid), 64'(m_held && m_age >= NE));
            chk("busy", 64'(busy), 64'(m_held && m_age < NE));
            if ((m_held && m_age >= NE) || (!m_held && m_zero)) begin
                chk("model out_data", 64'(out_data), 64'(m_data));
                chk("model out_addr", 64'(out_addr), 64'(m_addr));
            end
        end
    end

    task automatic send(input logic [NE*DW-1:0] v);
        int n;
        bit ok;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        ok = in_ready;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL send timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [NE*DW-1:0] v,
                           input logic [NE*DW-1:0] exp_d, input logic [NE*AW-1:0] exp_a);
        int lat;
        send(v);
        wait_result(lat);
        chk({name, " latency"}, 64'(lat), 64'(6));
        chk({name, " data"}, 64'(out_data), 64'(exp_d));
        chk({name, " addr"}, 64'(out_addr), 64'(exp_a));
        take_result();
    endtask

    function automatic logic [NE*DW-1:0] rand_vec();
        logic [NE*DW-1:0] v;
        for (int k = 0; k < NE; k++) begin
            case ($urandom_range(0, 3))
                0:       v[k*DW +: DW] = DW'($urandom_range(0, 3));
                1:       v[k*DW +: DW] = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7f;
                default: v[k*DW +: DW] = DW'($urandom_range(0, 255));
            endcase
        end
        return v;
    endfunction

    initial begin
        logic [NE*DW-1:0] md;
        logic [NE*AW-1:0] ma;
        int lat;
        int pulses;
        int acc;
        int cyc_n;
        bit will;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset in_ready", 64'(in_ready), 64'(1));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset out_data", 64'(out_data), 64'(0));
        chk("reset out_addr", 64'(out_addr), 64'(0));

        ref_sort(pack_s(-128, 127, -1, 0, 1, -2), md, ma);
        chk("model pin data", 64'(md), 64'(pack_s(127, 1, 0, -1, -2, -128)));
        chk("model pin addr", 64'(ma), 64'(pack_a(1, 4, 3, 2, 5, 0)));

        // Abort a sort with a two-edge reset; no result may appear afterwards.
        send(pack_s(5, 4, 3, 2, 1, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort in_ready", 64'(in_ready), 64'(1));
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort out_data", 64'(out_data), 64'(0));
        chk("abort out_addr", 64'(out_addr), 64'(0));
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort valid pulses", 64'(pulses), 64'(0));
        #1;

        run_dir("reverse", pack_s(0, 1, 2, 3, 4, 5), pack_s(5, 4, 3, 2, 1, 0),
                pack_a(5, 4, 3, 2, 1, 0));
        run_dir("extremes", pack_s(-128, 127, -1, 0, 1, -2), pack_s(127, 1, 0, -1, -2, -128),
                pack_a(1, 4, 3, 2, 5, 0));
        run_dir("all sevens", pack_s(7, 7, 7, 7, 7, 7), pack_s(7, 7, 7, 7, 7, 7),
                pack_a(0, 1, 2, 3, 4, 5));
        run_dir("ties", pack_s(3, 9, 3, 9, 3, 9), pack_s(9, 9, 9, 3, 3, 3),
                pack_a(1, 3, 5, 0, 2, 4));

        // Backpressure: result must hold while a new vector waits at the input.
        send(pack_s(10, -5, 33, -5, 0, 2));
        wait_result(lat);
        chk("bp latency", 64'(lat), 64'(6));
        #1;
        in_data  = pack_s(1, 2, 3, 4, 5, 6);
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp in_ready", 64'(in_ready), 64'(0));
            chk("bp out_valid", 64'(out_valid), 64'(1));
            chk("bp data", 64'(out_data), 64'(pack_s(33, 10, 2, 0, -5, -5)));
            chk("bp addr", 64'(out_addr), 64'(pack_a(2, 0, 5, 4, 1, 3)));
        end
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp idle in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("bp accept busy", 64'(busy), 64'(1));
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp second latency", 64'(lat), 64'(6));
        chk("bp second data", 64'(out_data), 64'(pack_s(6, 5, 4, 3, 2, 1)));
        chk("bp second addr", 64'(out_addr), 64'(pack_a(5, 4, 3, 2, 1, 0)));
        take_result();

        // Random traffic with input gaps and output backpressure; the model checks every cycle.
        acc   = 0;
        cyc_n = 0;
        while (acc < 1000 && cyc_n < 60000) begin
            @(negedge clk);
            #1;
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_data  = rand_vec();
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            will = in_valid && in_ready;
            @(posedge clk);
            cyc_n++;
            if (will) begin
                acc++;
                @(negedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        chk("random vectors accepted", 64'(acc), 64'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
